matrix_keypad_scanner: RTL and testbench

MATRIX_KEYPAD_SCANNER -- requirements
Module: matrix_keypad_scanner

---
 rtl/matrix_keypad_scanner.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_matrix_keypad_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_keypad_scanner.sv
// Matrix keypad scanner: synchronises active-low rows, walks the columns one
// per scan tick, debounces press and release, and queues key codes for a reader.
// Latency: a key code reaches kbrdata the clk after its push; pops take effect on the same edge.
// Backpressure: kbcs pops the head. A push into a full buffer with no pop is dropped and sets kb_ovf.
//
// Ports:
//   clk, rst_n      sole clock; asynchronous active-low reset
//   row[ROWS]       keypad rows, active-low, asynchronous to clk
//   col[COLS]       registered active-low column drive
//   kbcs            read strobe; pops one event per cycle while kb_valid
//   ovf_clr         synchronous clear of kb_ovf
//   kbrdata         head event code = row_idx*COLS + col_idx
//   kb_valid        event buffer non-empty
//   kb_ovf          sticky flag: an event was dropped
//   key_down        high while a debounced key is held
//
// Build option: define KEYPAD_FIFO_EN for a FIFO_DEPTH-entry event buffer.
// Without it the buffer is a single holding register and FIFO_DEPTH is ignored.

module matrix_keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 500000,
  parameter int DEBOUNCE   = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int CODE_W    = ($clog2(ROWS*COLS) < 1) ? 1 : $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  input  logic              kbcs,
  input  logic              ovf_clr,
  output logic [CODE_W-1:0] kbrdata,
  output logic              kb_valid,
  output logic              kb_ovf,
  output logic              key_down
);

  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW   = $clog2(SCAN_DIV);
  localparam int DB_W = $clog2(DEBOUNCE + 1);

  localparam logic [TW-1:0]   TICK_MAX = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]   COL_MAX  = CW'(COLS - 1);
  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED
  } state_t;

  // ---------------------------------------------------------------------------
  // Row synchroniser. Resets to all ones so no key appears pressed after reset.
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0] row_meta;
  logic [ROWS-1:0] row_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_s    <= '1;
    end else begin
      row_meta <= row;
      row_s    <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan tick: one clk pulse every SCAN_DIV cycles.
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Scan / debounce FSM
  // ---------------------------------------------------------------------------
  state_t            state, state_n;
  logic [CW-1:0]     col_idx, col_idx_n;
  logic [RW-1:0]     row_idx, row_idx_n;
  logic [ROWS-1:0]   row_pat, row_pat_n;
  logic [DB_W-1:0]   db_cnt, db_cnt_n;
  logic [DB_W-1:0]   rel_cnt, rel_cnt_n;
  logic [COLS-1:0]   col_n;
  logic [RW-1:0]     first_low;
  logic              any_low;
  logic              push;
  logic [CODE_W-1:0] push_code;

  assign any_low = (row_s != '1);

  // Lowest-index low row wins when several rows are pulled in one column.
  always_comb begin
    first_low = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!row_s[i]) first_low = RW'(i);
    end
  end

  always_comb begin
    state_n   = state;
    col_idx_n = col_idx;
    row_idx_n = row_idx;
    row_pat_n = row_pat;
    db_cnt_n  = db_cnt;
    rel_cnt_n = rel_cnt;
    push      = 1'b0;

    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          if (any_low) begin
            state_n   = ST_SCAN;
            col_idx_n = '0;
          end
        end

        ST_SCAN: begin
          if (any_low) begin
            row_idx_n = first_low;
            row_pat_n = row_s;
            db_cnt_n  = DB_W'(1);
            rel_cnt_n = '0;
            // With a one-tick debounce the latching tick already qualifies.
            if (DB_MAX == DB_W'(1)) begin
              push    = 1'b1;
              state_n = ST_PRESSED;
            end else begin
              state_n = ST_DEBOUNCE;
            end
          end else if (col_idx == COL_MAX) begin
            state_n = ST_IDLE;
          end else begin
            col_idx_n = col_idx + CW'(1);
          end
        end

        ST_DEBOUNCE: begin
          if (row_s == row_pat) begin
            db_cnt_n = db_cnt + DB_W'(1);
            if ((db_cnt + DB_W'(1)) == DB_MAX) begin
              push      = 1'b1;
              state_n   = ST_PRESSED;
              rel_cnt_n = '0;
            end
          end else begin
            state_n = ST_IDLE;
          end
        end

        ST_PRESSED: begin
          if (!any_low) begin
            if ((rel_cnt + DB_W'(1)) == DB_MAX) begin
              state_n   = ST_IDLE;
              rel_cnt_n = '0;
            end else begin
              rel_cnt_n = rel_cnt + DB_W'(1);
            end
          end else begin
            rel_cnt_n = '0;
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end

    // IDLE drives every column so any key pulls a row; otherwise one column low.
    if (state_n == ST_IDLE) begin
      col_n = '0;
    end else begin
      col_n = ~(COLS'(1) << col_idx_n);
    end

    push_code = CODE_W'(row_idx_n) * CODE_W'(COLS) + CODE_W'(col_idx_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      col_idx <= '0;
      row_idx <= '0;
      row_pat <= '1;
      db_cnt  <= '0;
      rel_cnt <= '0;
      col     <= '0;
    end else begin
      state   <= state_n;
      col_idx <= col_idx_n;
      row_idx <= row_idx_n;
      row_pat <= row_pat_n;
      db_cnt  <= db_cnt_n;
      rel_cnt <= rel_cnt_n;
      col     <= col_n;
    end
  end

  assign key_down = (state == ST_PRESSED);

  // ---------------------------------------------------------------------------
  // Event buffer
  // ---------------------------------------------------------------------------
  logic pop;
  logic push_ok;
  logic drop;

`ifdef KEYPAD_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr, rptr_nxt;
  logic [PTR_W:0]    count;
  logic              full;

  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign kb_valid = (count != '0);
  assign pop      = kbcs & kb_valid;
  // A pop frees a slot in the same cycle, so a full buffer still accepts.
  assign push_ok  = push & (~full | pop);
  assign drop     = push & ~push_ok;
  assign rptr_nxt = rptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      kbrdata <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop)     rptr <= rptr_nxt;

      if (push_ok && !pop)      count <= count + (PTR_W+1)'(1);
      else if (!push_ok && pop) count <= count - (PTR_W+1)'(1);

      // kbrdata is a register holding the head so it keeps its last value
      // once the buffer empties.
      if (pop) begin
        if (count == (PTR_W+1)'(1)) begin
          if (push_ok) kbrdata <= push_code;
        end else begin
          kbrdata <= mem[rptr_nxt];
        end
      end else if (!kb_valid && push_ok) begin
        kbrdata <= push_code;
      end
    end
  end
`else
  logic hold_vld;

  assign kb_valid = hold_vld;
  assign pop      = kbcs & hold_vld;
  assign push_ok  = push & (~hold_vld | pop);
  assign drop     = push & ~push_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
      kbrdata  <= '0;
    end else if (push_ok) begin
      hold_vld <= 1'b1;
      kbrdata  <= push_code;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  // A drop in the same cycle as a clear wins, so no loss goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_ovf <= 1'b0;
    end else if (drop) begin
      kb_ovf <= 1'b1;
    end else if (ovf_clr) begin
      kb_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
module tb_matrix_keypad_scanner;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;
`ifdef KEYPAD_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ROWS-1:0]   row;
  logic [COLS-1:0]   col;
  logic              kbcs = 1'b0;
  logic              ovf_clr = 1'b0;
  logic [CODE_W-1:0] kbrdata;
  logic              kb_valid;
  logic              kb_ovf;
  logic              key_down;

  bit held [ROWS*COLS];   // physical keys currently pressed, index r*COLS+c
  int cyc;                // posedges since reset release
  int checks = 0;
  int fails  = 0;
  int q[$];               // expected buffer contents, head first
  bit m_ovf = 1'b0;

  matrix_keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .kbcs(kbcs),
    .ovf_clr(ovf_clr), .kbrdata(kbrdata), .kb_valid(kb_valid),
    .kb_ovf(kb_ovf), .key_down(key_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Key switch matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (held[r*COLS+c] && col[c] == 1'b0) row[r] = 1'b0;
  end

  function automatic void model_push(input int code);
    if (q.size() < DEPTH) q.push_back(code);
    else m_ovf = 1'b1;
  endfunction

  task automatic wait_kd(input logic lvl, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (key_down === lvl) got = 1'b1;
    end
  endtask

  task automatic tap(input int code, output bit ok);
    bit g;
    ok = 1'b1;
    held[code] = 1'b1;
    wait_kd(1'b1, 200, g); ok = ok & g;
    repeat (5) @(negedge clk);
    held[code] = 1'b0;
    wait_kd(1'b0, 200, g); ok = ok & g;
    repeat (12) @(negedge clk);
  endtask

  // Stops at a negedge three posedges before a scan tick.
  task automatic align();
    do @(negedge clk); while (cyc % 4 != 1);
  endtask

  task automatic pop_one();
    kbcs = 1'b1;
    @(negedge clk);
    kbcs = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (col !== 4'b0000) begin fails++; $display("FAIL reset_col got %b exp 0000", col); end
    checks++; if (kb_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", kb_valid); end
    checks++; if (kbrdata !== 4'd0) begin fails++; $display("FAIL reset_data got %0d exp 0", kbrdata); end
    checks++; if (kb_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", kb_ovf); end
    checks++; if (key_down !== 1'b0) begin fails++; $display("FAIL reset_keydown got %b exp 0", key_down); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (kb_valid !== 1'b0) begin fails++; $display("FAIL idle_valid got %b exp 0", kb_valid); end
    checks++; if (col !== 4'b0000) begin fails++; $display("FAIL idle_col got %b exp 0000", col); end
  endtask

  task automatic test_single_key();
    bit g;
    held[6] = 1'b1;   // row1 / col2
    repeat (40) @(negedge clk);
    model_push(6);
    checks++; if (key_down !== 1'b1) begin fails++; $display("FAIL single_keydown got %b exp 1", key_down); end
    checks++; if (kb_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", kb_valid); end
    checks++; if (kbrdata !== 4'd6) begin fails++; $display("FAIL single_code got %0d exp 6", kbrdata); end
    held[6] = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (key_down !== 1'b1) begin fails++; $display("FAIL release_early got %b exp 1", key_down); end
    wait_kd(1'b0, 14, g);
    checks++; if (g !== 1'b1) begin fails++; $display("FAIL release_timeout got %b exp 1", g); end
    repeat (20) @(negedge clk);
    checks++; if (kbrdata !== 4'(q[0])) begin fails++; $display("FAIL single_head got %0d exp %0d", kbrdata, q[0]); end
    pop_one(); void'(q.pop_front());
    checks++; if (kb_valid !== 1'b0) begin fails++; $display("FAIL single_second_push got %b exp 0", kb_valid); end
  endtask

  task automatic test_glitch();
    bit kd_seen = 1'b0;
    align();
    held[0] = 1'b1;   // low across the detect and latch ticks, gone for the debounce tick
    repeat (5) begin @(negedge clk); kd_seen |= key_down; end
    held[0] = 1'b0;
    repeat (40) begin @(negedge clk); kd_seen |= key_down; end
    checks++; if (kd_seen !== 1'b0) begin fails++; $display("FAIL glitch_keydown got %b exp 0", kd_seen); end
    checks++; if (kb_valid !== 1'b0) begin fails++; $display("FAIL glitch_valid got %b exp 0", kb_valid); end
  endtask

  task automatic test_overflow();
    int codes[5] = '{0, 5, 10, 15, 3};
    bit ok;
    foreach (codes[i]) begin
      tap(codes[i], ok);
      checks++; if (ok !== 1'b1) begin fails++; $display("FAIL ovf_tap%0d got %b exp 1", i, ok); end
      model_push(codes[i]);
    end
    checks++; if (kb_ovf !== m_ovf) begin fails++; $display("FAIL ovf_flag got %b exp %b", kb_ovf, m_ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (kbrdata !== 4'(q[0])) begin fails++; $display("FAIL ovf_read%0d got %0d exp %0d", i, kbrdata, q[0]); end
      pop_one(); void'(q.pop_front());
    end
    checks++; if (kb_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got %b exp 0", kb_valid); end
    checks++; if (kb_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", kb_ovf); end
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0; m_ovf = 1'b0;
    checks++; if (kb_ovf !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b exp 0", kb_ovf); end
  endtask

  task automatic test_back_to_back();
    int fill[4] = '{1, 4, 8, 12};
    int off = 1;
    int start;
    bit g;
    for (int i = 0; i < DEPTH; i++) begin
      align();
      held[fill[i]] = 1'b1;
      start = cyc;
      wait_kd(1'b1, 200, g);
      checks++; if (g !== 1'b1) begin fails++; $display("FAIL fill%0d_timeout got %b exp 1", i, g); end
      if (i == 0) off = (cyc - start > 1) ? cyc - start : 1;
      held[fill[i]] = 1'b0;
      wait_kd(1'b0, 200, g);
      repeat (12) @(negedge clk);
      model_push(fill[i]);
    end
    // Code 5 shares column 1 with the first fill key, so its push lands at the same offset.
    align();
    held[5] = 1'b1;
    repeat (off - 1) @(negedge clk);
    kbcs = 1'b1;
    @(negedge clk);
    kbcs = 1'b0;
    void'(q.pop_front());
    model_push(5);
    checks++; if (key_down !== 1'b1) begin fails++; $display("FAIL b2b_push_edge got %b exp 1", key_down); end
    held[5] = 1'b0;
    wait_kd(1'b0, 200, g);
    repeat (12) @(negedge clk);
    checks++; if (kb_ovf !== m_ovf) begin fails++; $display("FAIL b2b_ovf got %b exp %b", kb_ovf, m_ovf); end
    while (q.size() > 0) begin
      checks++; if (kbrdata !== 4'(q[0])) begin fails++; $display("FAIL b2b_read got %0d exp %0d", kbrdata, q[0]); end
      pop_one(); void'(q.pop_front());
    end
    checks++; if (kb_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b exp 0", kb_valid); end
  endtask

  task automatic test_random();
    bit ok;
    int code, nr;
    for (int it = 0; it < 10; it++) begin
      code = $urandom_range(0, ROWS*COLS-1);
      tap(code, ok);
      checks++; if (ok !== 1'b1) begin fails++; $display("FAIL rnd%0d_tap got %b exp 1", it, ok); end
      model_push(code);
      checks++; if (kb_valid !== (q.size() != 0)) begin fails++; $display("FAIL rnd%0d_valid got %b exp %b", it, kb_valid, q.size() != 0); end
      checks++; if (kb_ovf !== m_ovf) begin fails++; $display("FAIL rnd%0d_ovf got %b exp %b", it, kb_ovf, m_ovf); end
      nr = $urandom_range(0, 2);
      for (int j = 0; j < nr && q.size() > 0; j++) begin
        checks++; if (kbrdata !== 4'(q[0])) begin fails++; $display("FAIL rnd%0d_read got %0d exp %0d", it, kbrdata, q[0]); end
        pop_one(); void'(q.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0; m_ovf = 1'b0;
        checks++; if (kb_ovf !== 1'b0) begin fails++; $display("FAIL rnd%0d_clr got %b exp 0", it, kb_ovf); end
      end
    end
  endtask

  task automatic test_reset_midpress();
    bit g;
    held[9] = 1'b1;
    wait_kd(1'b1, 200, g);
    checks++; if (g !== 1'b1) begin fails++; $display("FAIL midpress_timeout got %b exp 1", g); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0;
    checks++; if (col !== 4'b0000) begin fails++; $display("FAIL mrst_col got %b exp 0000", col); end
    checks++; if (kb_valid !== 1'b0) begin fails++; $display("FAIL mrst_valid got %b exp 0", kb_valid); end
    checks++; if (kbrdata !== 4'd0) begin fails++; $display("FAIL mrst_data got %0d exp 0", kbrdata); end
    checks++; if (kb_ovf !== 1'b0) begin fails++; $display("FAIL mrst_ovf got %b exp 0", kb_ovf); end
    checks++; if (key_down !== 1'b0) begin fails++; $display("FAIL mrst_keydown got %b exp 0", key_down); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_kd(1'b1, 200, g);
    model_push(9);
    checks++; if (g !== 1'b1) begin fails++; $display("FAIL repress_timeout got %b exp 1", g); end
    checks++; if (kbrdata !== 4'(q[0])) begin fails++; $display("FAIL repress_code got %0d exp %0d", kbrdata, q[0]); end
    held[9] = 1'b0;
    wait_kd(1'b0, 200, g);
    repeat (20) @(negedge clk);
    pop_one(); void'(q.pop_front());
    checks++; if (kb_valid !== 1'b0) begin fails++; $display("FAIL repress_single got %b exp 0", kb_valid); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_random();
    test_reset_midpress();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
